// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus arbiter: FSM state encoding and arbitration modes.
package sram_bus_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRdA,
        StRdD,
        StWr
    } bus_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Grant selector: round-robin from ptr+1 with wrap, or fixed priority with port 0 highest.
module rr_arbiter #(
    parameter int unsigned N_PORTS = 4,
    localparam int unsigned PTR_W = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic               i_mode,
    output logic [N_PORTS-1:0] o_grant
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        if (i_mode) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (i_req[i[PTR_W-1:0]] && !w_found) begin
                    o_grant[i[PTR_W-1:0]] = 1'b1;
                    w_found               = 1'b1;
                end
            end
        end else begin
            // Candidate order ptr+1 .. ptr+N, folded back into 0..N-1.
            for (int unsigned i = 1; i <= N_PORTS; i++) begin
                w_sum = {1'b0, i_ptr} + SUM_W'(i);
                if (w_sum >= SUM_W'(N_PORTS)) begin
                    w_sum = w_sum - SUM_W'(N_PORTS);
                end
                w_idx = w_sum[PTR_W-1:0];
                if (i_req[w_idx] && !w_found) begin
                    o_grant[w_idx] = 1'b1;
                    w_found        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_bus_arbiter_n.sv
// N-master to single-slave SRAM line bus arbiter; one downstream transaction in flight.
module sram_bus_arbiter_n import sram_bus_pkg::*; #(
    parameter int unsigned N_PORTS  = 4,
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_PORTS-1:0]               m_r_req,
    input  logic [N_PORTS*32-1:0]            m_r_addr,
    input  logic [N_PORTS*6-1:0]             m_r_type,
    output logic [N_PORTS-1:0]               m_r_rdy,
    output logic [DATA_W-1:0]                m_re_data,
    output logic [N_PORTS-1:0]               m_re_valid,
    input  logic [N_PORTS-1:0]               m_r_abort,
    input  logic [N_PORTS-1:0]               m_w_req,
    input  logic [N_PORTS*32-1:0]            m_w_addr,
    input  logic [N_PORTS*DATA_W-1:0]        m_w_data,
    input  logic [N_PORTS*6-1:0]             m_w_type,
    input  logic [N_PORTS*(DATA_W/16)-1:0]   m_w_strb,
    output logic [N_PORTS-1:0]               m_w_rdy,
    output logic                             s_r_req,
    output logic [31:0]                      s_r_addr,
    output logic [5:0]                       s_r_type,
    input  logic                             s_r_rdy,
    input  logic [DATA_W-1:0]                s_re_data,
    input  logic                             s_re_valid,
    output logic                             s_w_req,
    output logic [31:0]                      s_w_addr,
    output logic [DATA_W-1:0]                s_w_data,
    output logic [5:0]                       s_w_type,
    output logic [DATA_W/16-1:0]             s_w_strb,
    input  logic                             s_w_rdy
);

    localparam int unsigned STRB_W = DATA_W / 16;
    localparam int unsigned PTR_W  = $clog2(N_PORTS);

    bus_state_e         r_state;
    logic [PTR_W-1:0]   r_gnt;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_drop;

    logic [N_PORTS-1:0] w_req_vec;
    logic [N_PORTS-1:0] w_grant_oh;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_any_req;

    assign w_req_vec = m_r_req | m_w_req;
    assign w_any_req = |w_req_vec;

    rr_arbiter #(
        .N_PORTS (N_PORTS)
    ) u_arb (
        .i_req   (w_req_vec),
        .i_ptr   (r_ptr),
        .i_mode  (ARB_MODE == ARB_FIXED),
        .o_grant (w_grant_oh)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (w_grant_oh[i[PTR_W-1:0]]) begin
                w_grant_idx = i[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_gnt   <= '0;
            r_ptr   <= PTR_W'(N_PORTS - 1);
            r_drop  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_drop <= 1'b0;
                    if (w_any_req) begin
                        r_gnt   <= w_grant_idx;
                        r_ptr   <= w_grant_idx;
                        r_state <= m_w_req[w_grant_idx] ? StWr : StRdA;
                    end
                end
                StRdA: begin
                    if (m_r_abort[r_gnt]) r_drop <= 1'b1;
                    if (s_r_rdy) r_state <= StRdD;
                end
                StRdD: begin
                    if (m_r_abort[r_gnt]) r_drop <= 1'b1;
                    // The beat is always consumed; drop only hides it from the master.
                    if (s_re_valid) begin
                        r_state <= StIdle;
                        r_drop  <= 1'b0;
                    end
                end
                StWr: begin
                    if (s_w_rdy) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        s_r_req    = (r_state == StRdA);
        s_r_addr   = m_r_addr[32*r_gnt +: 32];
        s_r_type   = m_r_type[6*r_gnt +: 6];
        s_w_req    = (r_state == StWr);
        s_w_addr   = m_w_addr[32*r_gnt +: 32];
        s_w_data   = m_w_data[DATA_W*r_gnt +: DATA_W];
        s_w_type   = m_w_type[6*r_gnt +: 6];
        s_w_strb   = m_w_strb[STRB_W*r_gnt +: STRB_W];
        m_re_data  = s_re_data;
        m_r_rdy    = '0;
        m_w_rdy    = '0;
        m_re_valid = '0;
        unique case (r_state)
            StRdA:   m_r_rdy[r_gnt]    = s_r_rdy;
            StRdD:   m_re_valid[r_gnt] = s_re_valid & ~r_drop;
            StWr:    m_w_rdy[r_gnt]    = s_w_rdy;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_bus_arbiter_n.sv
// Randomized and directed bench for sram_bus_arbiter_n against a transaction-level model.
module tb_sram_bus_arbiter_n;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int SW = DW / 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, sel_b;

    logic [N-1:0]      m_r_req, m_r_abort, m_w_req;
    logic [N*32-1:0]   m_r_addr, m_w_addr;
    logic [N*6-1:0]    m_r_type, m_w_type;
    logic [N*DW-1:0]   m_w_data;
    logic [N*SW-1:0]   m_w_strb;
    logic              s_r_rdy, s_re_valid, s_w_rdy;
    logic [DW-1:0]     s_re_data;

    logic [31:0] p_raddr [N];
    logic [5:0]  p_rtype [N];
    logic [31:0] p_waddr [N];
    logic [5:0]  p_wtype [N];
    logic [DW-1:0] p_wdata [N];
    logic [SW-1:0] p_wstrb [N];

    logic [N-1:0] a_m_r_rdy, a_m_re_valid, a_m_w_rdy, b_m_r_rdy, b_m_re_valid, b_m_w_rdy;
    logic [N-1:0] v_m_r_rdy, v_m_re_valid, v_m_w_rdy;
    logic [DW-1:0] a_m_re_data, b_m_re_data, v_m_re_data;
    logic a_s_r_req, b_s_r_req, v_s_r_req, a_s_w_req, b_s_w_req, v_s_w_req;
    logic [31:0] a_s_r_addr, b_s_r_addr, v_s_r_addr, a_s_w_addr, b_s_w_addr, v_s_w_addr;
    logic [5:0] a_s_r_type, b_s_r_type, v_s_r_type, a_s_w_type, b_s_w_type, v_s_w_type;
    logic [DW-1:0] a_s_w_data, b_s_w_data, v_s_w_data;
    logic [SW-1:0] a_s_w_strb, b_s_w_strb, v_s_w_strb;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr;
    bit m_fixed;

    sram_bus_arbiter_n #(.N_PORTS(N), .DATA_W(DW), .ARB_MODE(0)) u_dut_rr (
        .clk(clk), .rst_n(rst_a),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(a_m_r_rdy),
        .m_re_data(a_m_re_data), .m_re_valid(a_m_re_valid), .m_r_abort(m_r_abort),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
        .m_w_strb(m_w_strb), .m_w_rdy(a_m_w_rdy),
        .s_r_req(a_s_r_req), .s_r_addr(a_s_r_addr), .s_r_type(a_s_r_type), .s_r_rdy(s_r_rdy),
        .s_re_data(s_re_data), .s_re_valid(s_re_valid),
        .s_w_req(a_s_w_req), .s_w_addr(a_s_w_addr), .s_w_data(a_s_w_data),
        .s_w_type(a_s_w_type), .s_w_strb(a_s_w_strb), .s_w_rdy(s_w_rdy)
    );

    sram_bus_arbiter_n #(.N_PORTS(N), .DATA_W(DW), .ARB_MODE(1)) u_dut_fx (
        .clk(clk), .rst_n(rst_b),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(b_m_r_rdy),
        .m_re_data(b_m_re_data), .m_re_valid(b_m_re_valid), .m_r_abort(m_r_abort),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
        .m_w_strb(m_w_strb), .m_w_rdy(b_m_w_rdy),
        .s_r_req(b_s_r_req), .s_r_addr(b_s_r_addr), .s_r_type(b_s_r_type), .s_r_rdy(s_r_rdy),
        .s_re_data(s_re_data), .s_re_valid(s_re_valid),
        .s_w_req(b_s_w_req), .s_w_addr(b_s_w_addr), .s_w_data(b_s_w_data),
        .s_w_type(b_s_w_type), .s_w_strb(b_s_w_strb), .s_w_rdy(s_w_rdy)
    );

    // The idle instance is held in reset; checks look at whichever one is selected.
    assign v_m_r_rdy    = sel_b ? b_m_r_rdy    : a_m_r_rdy;
    assign v_m_re_valid = sel_b ? b_m_re_valid : a_m_re_valid;
    assign v_m_w_rdy    = sel_b ? b_m_w_rdy    : a_m_w_rdy;
    assign v_m_re_data  = sel_b ? b_m_re_data  : a_m_re_data;
    assign v_s_r_req    = sel_b ? b_s_r_req    : a_s_r_req;
    assign v_s_r_addr   = sel_b ? b_s_r_addr   : a_s_r_addr;
    assign v_s_r_type   = sel_b ? b_s_r_type   : a_s_r_type;
    assign v_s_w_req    = sel_b ? b_s_w_req    : a_s_w_req;
    assign v_s_w_addr   = sel_b ? b_s_w_addr   : a_s_w_addr;
    assign v_s_w_type   = sel_b ? b_s_w_type   : a_s_w_type;
    assign v_s_w_data   = sel_b ? b_s_w_data   : a_s_w_data;
    assign v_s_w_strb   = sel_b ? b_s_w_strb   : a_s_w_strb;

    always_comb begin
        m_r_addr = '0;
        m_r_type = '0;
        m_w_addr = '0;
        m_w_type = '0;
        m_w_data = '0;
        m_w_strb = '0;
        for (int p = 0; p < N; p++) begin
            m_r_addr[p*32 +: 32] = p_raddr[p];
            m_r_type[p*6 +: 6]   = p_rtype[p];
            m_w_addr[p*32 +: 32] = p_waddr[p];
            m_w_type[p*6 +: 6]   = p_wtype[p];
            m_w_data[p*DW +: DW] = p_wdata[p];
            m_w_strb[p*SW +: SW] = p_wstrb[p];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int idx = -1;
        int cnt = 0;
        for (int p = 0; p < N; p++) begin
            if (v[p]) begin
                idx = p;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    // Model: next winner from the pending request set.
    function automatic int pick(input logic [N-1:0] req, input int ptr, input bit fixed);
        if (fixed) begin
            for (int p = 0; p < N; p++) if (req[p]) return p;
        end else begin
            for (int k = 1; k <= N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic raise(input int p, input bit wr);
        if (wr) begin
            p_waddr[p] = $urandom;
            p_wtype[p] = 6'($urandom);
            p_wdata[p] = rand_line();
            p_wstrb[p] = SW'($urandom);
            m_w_req[p] = 1'b1;
        end else begin
            p_raddr[p] = $urandom;
            p_rtype[p] = 6'($urandom);
            m_r_req[p] = 1'b1;
        end
    endtask

    // Entered on a negedge with the DUT idle and requests settled; leaves on the bubble negedge.
    task automatic run_txn(input bit do_abort, output int obs, output bit obs_wr);
        int g;
        int d;
        logic [N-1:0] oh;
        logic [DW-1:0] rdata;
        g = pick(m_r_req | m_w_req, m_ptr, m_fixed);
        if (g < 0) begin
            $display("FAIL pick no pending request");
            $fatal(1, "bench error");
        end
        obs_wr = m_w_req[g];
        m_ptr  = g;
        oh     = N'(1) << g;
        obs    = -1;
        @(negedge clk);
        chk("s_w_req", v_s_w_req, obs_wr);
        chk("s_r_req", v_s_r_req, !obs_wr);
        if (obs_wr) begin
            chk("s_w_addr", v_s_w_addr, p_waddr[g]);
            chk("s_w_type", v_s_w_type, p_wtype[g]);
            chk("s_w_data", v_s_w_data, p_wdata[g]);
            chk("s_w_strb", v_s_w_strb, p_wstrb[g]);
            d = $urandom_range(0, 2);
            for (int i = 0; i < d; i++) begin
                s_r_rdy    = 1'($urandom);
                s_re_valid = 1'($urandom);
                #1;
                chk("wr_wait_rdy", {v_m_w_rdy, v_m_r_rdy, v_m_re_valid}, '0);
                @(negedge clk);
            end
            s_r_rdy    = 1'b0;
            s_re_valid = 1'b0;
            s_w_rdy    = 1'b1;
            #1;
            chk("m_w_rdy", v_m_w_rdy, oh);
            obs = oh_idx(v_m_w_rdy);
            @(negedge clk);
            s_w_rdy    = 1'b0;
            m_w_req[g] = 1'b0;
        end else begin
            chk("s_r_addr", v_s_r_addr, p_raddr[g]);
            chk("s_r_type", v_s_r_type, p_rtype[g]);
            d = $urandom_range(0, 2);
            for (int i = 0; i < d; i++) begin
                s_w_rdy    = 1'($urandom);
                s_re_valid = 1'($urandom);
                #1;
                chk("rda_wait", {v_m_w_rdy, v_m_r_rdy, v_m_re_valid}, '0);
                @(negedge clk);
            end
            s_w_rdy    = 1'b0;
            s_re_valid = 1'b0;
            s_r_rdy    = 1'b1;
            #1;
            chk("m_r_rdy", v_m_r_rdy, oh);
            obs = oh_idx(v_m_r_rdy);
            @(negedge clk);
            s_r_rdy    = 1'b0;
            m_r_req[g] = 1'b0;
            d = $urandom_range(do_abort ? 1 : 0, 3);
            for (int i = 0; i < d; i++) begin
                if (i == 0) m_r_abort[do_abort ? g : (g + 1) % N] = 1'b1;
                s_w_rdy = 1'($urandom);
                s_r_rdy = 1'($urandom);
                #1;
                chk("rdd_wait", {v_m_w_rdy, v_m_r_rdy, v_m_re_valid}, '0);
                @(negedge clk);
                m_r_abort = '0;
            end
            s_w_rdy    = 1'b0;
            s_r_rdy    = 1'b0;
            rdata      = rand_line();
            s_re_data  = rdata;
            s_re_valid = 1'b1;
            #1;
            chk("m_re_valid", v_m_re_valid, do_abort ? '0 : oh);
            chk("m_re_data", v_m_re_data, rdata);
            @(negedge clk);
            s_re_valid = 1'b0;
        end
        chk("bubble", {v_s_r_req, v_s_w_req}, 2'b00);
        chk("grant", obs, g);
    endtask

    task automatic drain();
        int o;
        bit w;
        while (|(m_r_req | m_w_req)) run_txn(1'b0, o, w);
    endtask

    initial begin
        int obs;
        bit wr;
        int seq [5];
        seq = '{0, 1, 2, 3, 0};
        rst_a = 1'b0;
        rst_b = 1'b0;
        sel_b = 1'b0;
        m_fixed = 1'b0;
        m_ptr = N - 1;
        m_r_req = '0;
        m_w_req = '0;
        m_r_abort = '0;
        s_r_rdy = 1'b0;
        s_w_rdy = 1'b0;
        s_re_valid = 1'b0;
        s_re_data = '0;
        for (int p = 0; p < N; p++) begin
            p_raddr[p] = '0; p_rtype[p] = '0; p_waddr[p] = '0;
            p_wtype[p] = '0; p_wdata[p] = '0; p_wstrb[p] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outputs", {v_s_r_req, v_s_w_req, v_m_r_rdy, v_m_w_rdy, v_m_re_valid}, '0);
        rst_a = 1'b1;
        @(negedge clk);

        // Round-robin with all four ports reading continuously.
        for (int p = 0; p < N; p++) raise(p, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_txn(1'b0, obs, wr);
            chk("rr_order", obs, seq[i]);
            raise(obs, 1'b0);
        end
        drain();

        // Write wins over read within the same port.
        raise(2, 1'b1);
        raise(2, 1'b0);
        run_txn(1'b0, obs, wr);
        chk("wr_first", {wr, 8'(obs)}, {1'b1, 8'd2});
        run_txn(1'b0, obs, wr);
        chk("rd_second", {wr, 8'(obs)}, {1'b0, 8'd2});

        // Aborted read on port 0.
        raise(0, 1'b0);
        run_txn(1'b1, obs, wr);

        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 3) == 0 && !m_w_req[p]) raise(p, 1'b1);
                if ($urandom_range(0, 2) == 0 && !m_r_req[p]) raise(p, 1'b0);
            end
            if (!(|(m_r_req | m_w_req))) raise($urandom_range(0, N - 1), 1'($urandom));
            run_txn($urandom_range(0, 3) == 0, obs, wr);
        end
        drain();

        // Reset while waiting for read data, then a late data beat.
        raise(2, 1'b0);
        @(negedge clk);
        chk("rst_rd_req", v_s_r_req, 1'b1);
        s_r_rdy = 1'b1;
        @(negedge clk);
        s_r_rdy = 1'b0;
        m_r_req[2] = 1'b0;
        #2 rst_a = 1'b0;
        #1;
        chk("rst_async", {v_s_r_req, v_s_w_req, v_m_r_rdy, v_m_w_rdy, v_m_re_valid}, '0);
        @(negedge clk);
        rst_a = 1'b1;
        s_re_data = rand_line();
        s_re_valid = 1'b1;
        #1;
        chk("late_valid", v_m_re_valid, '0);
        @(negedge clk);
        s_re_valid = 1'b0;
        chk("post_rst_idle", {v_s_r_req, v_s_w_req, v_m_re_valid}, '0);
        m_ptr = N - 1;
        raise(0, 1'b0);
        raise(3, 1'b0);
        run_txn(1'b0, obs, wr);
        chk("post_rst_grant", obs, 0);
        drain();

        // Fixed-priority instance: port 1 starves port 3.
        rst_a = 1'b0;
        sel_b = 1'b1;
        rst_b = 1'b1;
        m_fixed = 1'b1;
        m_ptr = N - 1;
        @(negedge clk);
        raise(1, 1'b0);
        raise(3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, obs, wr);
            chk("fixed_port1", obs, 1);
            raise(1, 1'b0);
        end
        m_r_req[1] = 1'b0;
        run_txn(1'b0, obs, wr);
        chk("fixed_port3", obs, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter_n.md
SRAM_BUS_ARBITER_N -- requirements
Module: sram_bus_arbiter_n

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, master port count (legal range 2..8).
REQ-002 SHALL have parameter DATA_W, default 256, line data width; the strobe width SHALL be DATA_W/16.
REQ-003 SHALL have parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-004 SHALL have the following ports, one per line:
clk  in  1  sole clock; all state updates on its rising edge
rst_n  in  1  asynchronous, active-low reset
m_r_req  in  N_PORTS  per-port read request
m_r_addr  in  N_PORTS*32  per-port read address
m_r_type  in  N_PORTS*6  per-port read type
m_r_rdy  out  N_PORTS  read address accepted
m_re_data  out  DATA_W  read data, shared by all ports
m_re_valid  out  N_PORTS  read data valid, per port
m_r_abort  in  N_PORTS  discard the pending read's data
m_w_req  in  N_PORTS  per-port write request
m_w_addr  in  N_PORTS*32  per-port write address
m_w_data  in  N_PORTS*DATA_W  per-port write data
m_w_type  in  N_PORTS*6  per-port write type
m_w_strb  in  N_PORTS*DATA_W/16  per-port write strobe
m_w_rdy  out  N_PORTS  write accepted
s_r_req / s_r_addr / s_r_type  out  1/32/6  downstream read request
s_r_rdy  in  1  downstream read accept
s_re_data / s_re_valid  in  DATA_W/1  downstream read return
s_w_req / s_w_addr / s_w_data / s_w_type / s_w_strb  out  1/32/DATA_W/6/DATA_W/16  downstream write
s_w_rdy  in  1  downstream write accept

Function
REQ-005 SHALL implement an FSM with states IDLE, RD_A, RD_D and WR, and SHALL have at most one downstream transaction outstanding.
REQ-006 In IDLE with any request present: round-robin mode SHALL grant the first requesting port found scanning upward (with wrap) from ptr+1; fixed mode SHALL grant the lowest requesting index.
REQ-007 Within the granted port, a write SHALL take priority over a read. The grant index and type SHALL be registered, the FSM SHALL enter WR or RD_A on the next cycle, and ptr SHALL be set to the granted port.
REQ-008 In RD_A: s_r_req=1 with the granted port's addr/type; m_r_rdy[g]=s_r_rdy; on s_r_rdy, go to RD_D.
REQ-009 In RD_D: m_re_data=s_re_data; m_re_valid[g]=s_re_valid & ~drop; on s_re_valid, go to IDLE.
REQ-010 In WR: s_w_req=1 with the granted port's fields; m_w_rdy[g]=s_w_rdy; on s_w_rdy, go to IDLE.
REQ-011 All rdy/valid outputs of non-granted ports SHALL be 0. Masters SHALL hold req and fields stable until rdy.
REQ-012 m_r_abort[g] in RD_A or RD_D SHALL set a sticky drop flag. It SHALL NOT withdraw s_r_req. The data beat is consumed silently, and drop SHALL clear on entering IDLE.
REQ-013 Latency: 1 cycle from request to s_*_req; 1 IDLE bubble between back-to-back transactions.
REQ-014 s_re_valid SHALL be ignored outside RD_D, and s_w_rdy / s_r_rdy SHALL be ignored outside their states.

Reset
REQ-015 rst_n low SHALL asynchronously force the following: state=IDLE, ptr=N_PORTS-1 (so port 0 wins first), drop=0, all s_*_req=0, and all m_*_rdy/m_re_valid=0.
REQ-016 Reset mid-transaction SHALL abandon the transaction; a late s_re_valid SHALL be ignored.

Structure
REQ-017 FSM state encoding and the ARB_MODE constants SHALL live in the shared sram_bus package.
REQ-018 The grant logic SHALL be one sub-module, rr_arbiter (request vector, ptr, mode -> one-hot grant).

Verification
REQ-019 Round-robin, ports 0..3 all requesting reads continuously: grants SHALL occur in order 0,1,2,3,0.
REQ-020 ARB_MODE=1, ports 1 and 3 requesting: port 1 SHALL be served repeatedly and port 3 SHALL starve.
REQ-021 Port 2 raises w_req and r_req together: the write SHALL be issued first (s_w_req), then the read.
REQ-022 Port 0 read with m_r_abort pulsed in RD_D: s_re_valid SHALL produce m_re_valid=0, then IDLE.
REQ-023 rst_n asserted while in RD_D, then s_re_valid=1: all m_re_valid SHALL stay 0, and the next grant SHALL go to port 0.
